// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit that drives the data memory.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } mau_state_e;

  localparam logic [4:0] OP_SW      = 5'b00111;
  localparam logic [4:0] OP_LW      = 5'b01000;
  localparam int         MAX_RD_LAT = 3;

endpackage

// File: rtl/mem_lat_counter.sv
// Two-bit down-counter that times the read latency of the data memory.
module mem_lat_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [1:0] i_value,
  output logic       o_zero
);

  logic [1:0] r_count;

  // Load wins over decrement; the count parks at zero until reloaded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= 2'd0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != 2'd0)) begin
      r_count <= r_count - 2'd1;
    end
  end

  assign o_zero = (r_count == 2'd0);

endmodule

// File: rtl/mem_access_unit.sv
// Turns one decoded load/store request into a timed transaction on a synchronous data memory,
// returning a one-cycle response pulse and stalling the pipeline while busy.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              ctrl_sw,
  input  logic              ctrl_lw,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err,
  output logic              stall,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q
);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_badRdLat
    $error("mem_access_unit: RD_LAT must be within 1..3");
  end

  mau_state_e        r_state;
  logic              r_errLatched;
  logic              r_rspValid;
  logic              r_err;
  logic [DATA_W-1:0] r_rspRdata;
  logic [ADDR_W-1:0] r_dmemAddr;
  logic [DATA_W-1:0] r_dmemData;
  logic              r_dmemWren;

  logic w_accept;
  logic w_rangeErr;
  logic w_illegal;
  logic w_latZero;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_rangeErr = |addr[31:ADDR_W];
  assign w_illegal  = ctrl_sw && ctrl_lw;

  mem_lat_counter u_latCounter (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_accept),
    .i_en    (r_state == READ_WAIT),
    .i_value (2'(RD_LAT)),
    .o_zero  (w_latZero)
  );

  // Response strobes and the write enable default low so each is a single-cycle pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_errLatched <= 1'b0;
      r_rspValid   <= 1'b0;
      r_err        <= 1'b0;
      r_rspRdata   <= '0;
      r_dmemAddr   <= '0;
      r_dmemData   <= '0;
      r_dmemWren   <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      r_err      <= 1'b0;
      r_dmemWren <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dmemAddr   <= addr[ADDR_W-1:0];
            r_dmemData   <= wdata;
            r_errLatched <= w_rangeErr || w_illegal;
            if (ctrl_sw && !ctrl_lw) begin
              r_state    <= WRITE;
              r_dmemWren <= !w_rangeErr;
            end else if (ctrl_lw && !ctrl_sw) begin
              r_state <= READ_WAIT;
            end else begin
              // No-op or illegal strobe pair: respond next cycle without touching memory.
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_err      <= w_rangeErr || w_illegal;
              if (w_illegal) begin
                r_rspRdata <= '0;
              end
            end
          end
        end
        WRITE: begin
          r_state    <= RESP;
          r_rspValid <= 1'b1;
          r_err      <= r_errLatched;
        end
        READ_WAIT: begin
          if (w_latZero) begin
            r_state    <= RESP;
            r_rspValid <= 1'b1;
            r_err      <= r_errLatched;
            r_rspRdata <= r_errLatched ? '0 : dmem_q;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign stall     = (r_state != IDLE);
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign err       = r_err;
  assign dmem_addr = r_dmemAddr;
  assign dmem_data = r_dmemData;
  assign dmem_wren = r_dmemWren;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: two units (read latency 1 and 3) against behavioural memories and a reference model.
module tb_mem_access_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rstN1, rstN3, reqValid1, reqValid3, ctrlSw, ctrlLw;
  logic [31:0] addrIn, wdataIn;

  logic        ready1, rspValid1, err1, stall1, wren1;
  logic [31:0] rdata1, dmemData1, q1;
  logic [11:0] dmemAddr1;
  logic        ready3, rspValid3, err3, stall3, wren3;
  logic [31:0] rdata3, dmemData3, q3;
  logic [11:0] dmemAddr3;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clock(clock), .reset(rstN1), .req_valid(reqValid1), .req_ready(ready1),
    .ctrl_sw(ctrlSw), .ctrl_lw(ctrlLw), .addr(addrIn), .wdata(wdataIn),
    .rsp_valid(rspValid1), .rsp_rdata(rdata1), .err(err1), .stall(stall1),
    .dmem_addr(dmemAddr1), .dmem_data(dmemData1), .dmem_wren(wren1), .dmem_q(q1)
  );

  mem_access_unit #(.ADDR_W(12), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clock(clock), .reset(rstN3), .req_valid(reqValid3), .req_ready(ready3),
    .ctrl_sw(ctrlSw), .ctrl_lw(ctrlLw), .addr(addrIn), .wdata(wdataIn),
    .rsp_valid(rspValid3), .rsp_rdata(rdata3), .err(err3), .stall(stall3),
    .dmem_addr(dmemAddr3), .dmem_data(dmemData3), .dmem_wren(wren3), .dmem_q(q3)
  );

  // Unwritten memory words hold a known address-derived pattern
  function automatic logic [31:0] seedWord(input logic [11:0] a);
    return 32'h5A00_0000 | {a, a, 8'h3C};
  endfunction

  // Behavioural synchronous memories with read latency 1 and 3
  logic [31:0] mem1 [4096];
  bit          wr1  [4096];
  logic [31:0] pipe1;
  always @(posedge clock) begin
    if (wren1) begin
      mem1[dmemAddr1] <= dmemData1;
      wr1[dmemAddr1]  <= 1'b1;
    end
    pipe1 <= wr1[dmemAddr1] ? mem1[dmemAddr1] : seedWord(dmemAddr1);
  end
  assign q1 = pipe1;

  logic [31:0] mem3 [4096];
  bit          wr3  [4096];
  logic [31:0] pipe3 [3];
  always @(posedge clock) begin
    if (wren3) begin
      mem3[dmemAddr3] <= dmemData3;
      wr3[dmemAddr3]  <= 1'b1;
    end
    pipe3[0] <= wr3[dmemAddr3] ? mem3[dmemAddr3] : seedWord(dmemAddr3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign q3 = pipe3[2];

  // Selected-DUT view for the tasks
  bit          sel;
  logic        mReady, mRspValid, mErr, mStall, mWren;
  logic [11:0] mDmemAddr;
  logic [31:0] mDmemData, mRdata;
  always_comb begin
    mReady = ready1; mRspValid = rspValid1; mErr = err1; mStall = stall1; mWren = wren1;
    mDmemAddr = dmemAddr1; mDmemData = dmemData1; mRdata = rdata1;
    if (sel) begin
      mReady = ready3; mRspValid = rspValid3; mErr = err3; mStall = stall3; mWren = wren3;
      mDmemAddr = dmemAddr3; mDmemData = dmemData3; mRdata = rdata3;
    end
  end

  // Reference model: architectural memory contents of each unit
  logic [31:0] refMem1 [4096];
  logic [31:0] refMem3 [4096];

  function automatic logic [31:0] refRead(input bit s, input logic [11:0] a);
    return s ? refMem3[a] : refMem1[a];
  endfunction

  task automatic refWrite(input bit s, input logic [11:0] a, input logic [31:0] d);
    if (s) refMem3[a] = d;
    else   refMem1[a] = d;
  endtask

  // Drives one request and records what came back; cycle 1 is the cycle after the accept edge
  task automatic applyStimulus(input bit s, input logic sw, input logic lw,
                               input logic [31:0] a, input logic [31:0] wd,
                               output int lat, output logic gotErr, output logic [31:0] gotData,
                               output int wrenCnt, output int wrenCyc,
                               output logic [11:0] wAddr, output logic [31:0] wData,
                               output bit stallOk);
    int guard;
    guard = 0;
    sel = s;
    @(negedge clock);
    while (!mReady && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    ctrlSw = sw; ctrlLw = lw; addrIn = a; wdataIn = wd;
    if (s) reqValid3 = 1'b1;
    else   reqValid1 = 1'b1;
    lat = -1; gotErr = 1'b0; gotData = '0; wrenCnt = 0; wrenCyc = -1;
    wAddr = '0; wData = '0; stallOk = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      reqValid1 = 1'b0;
      reqValid3 = 1'b0;
      if (mWren) begin
        wrenCnt++;
        wrenCyc = c;
        wAddr = mDmemAddr;
        wData = mDmemData;
      end
      if (!mStall) stallOk = 1'b0;
      if (mRspValid) begin
        lat = c;
        gotErr = mErr;
        gotData = mRdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({mReady, mRspValid, mErr, mStall, mWren, mDmemAddr, mDmemData, mRdata} !==
          {1'b1, 4'b0000, 12'h000, 32'h0, 32'h0}) begin
        errors++;
        $display("[TB] FAIL reset_values dut%0d: got rdy=%b rv=%b err=%b stall=%b wren=%b addr=%h data=%h rdata=%h",
                 s, mReady, mRspValid, mErr, mStall, mWren, mDmemAddr, mDmemData, mRdata);
      end
    end
  endtask

  task automatic test_store();
    int lat, wc, wcyc; logic e; logic [31:0] d, wdat; logic [11:0] wa; bit so;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h005, 32'hDEADBEEF, lat, e, d, wc, wcyc, wa, wdat, so);
    refWrite(1'b0, 12'h005, 32'hDEADBEEF);
    checks++;
    if (lat !== 2 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_resp: got lat=%0d err=%b, expected lat=2 err=0", lat, e);
    end
    checks++;
    if (wc !== 1 || wcyc !== 1 || wa !== 12'h005 || wdat !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL store_wren: got cnt=%0d cyc=%0d addr=%h data=%h, expected 1/1/005/deadbeef", wc, wcyc, wa, wdat);
    end
  endtask

  task automatic test_load_lat1();
    int lat, wc, wcyc; logic e; logic [31:0] d, wdat; logic [11:0] wa; bit so;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h005, 32'h0, lat, e, d, wc, wcyc, wa, wdat, so);
    checks++;
    if (lat !== 3 || e !== 1'b0 || d !== refRead(1'b0, 12'h005) || wc !== 0 || !so) begin
      errors++;
      $display("[TB] FAIL load_lat1: got lat=%0d err=%b rdata=%h wren=%0d stall=%b, expected lat=3 err=0 rdata=%h wren=0 stall=1",
               lat, e, d, wc, so, refRead(1'b0, 12'h005));
    end
  endtask

  task automatic test_range();
    int lat, wc, wcyc; logic e; logic [31:0] d, wdat; logic [11:0] wa; bit so;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678, lat, e, d, wc, wcyc, wa, wdat, so);
    checks++;
    if (lat !== 2 || e !== 1'b1 || wc !== 0) begin
      errors++;
      $display("[TB] FAIL range_store: got lat=%0d err=%b wren=%0d, expected lat=2 err=1 wren=0", lat, e, wc);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_2003, 32'h0, lat, e, d, wc, wcyc, wa, wdat, so);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL range_load: got lat=%0d err=%b rdata=%h, expected lat=3 err=1 rdata=0", lat, e, d);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, lat, e, d, wc, wcyc, wa, wdat, so);
    checks++;
    if (lat !== 3 || e !== 1'b0 || d !== refRead(1'b0, 12'h000)) begin
      errors++;
      $display("[TB] FAIL range_followup_load: got lat=%0d err=%b rdata=%h, expected lat=3 err=0 rdata=%h",
               lat, e, d, refRead(1'b0, 12'h000));
    end
  endtask

  task automatic test_illegal();
    int lat, wc, wcyc; logic e; logic [31:0] d, wdat; logic [11:0] wa; bit so;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFF, lat, e, d, wc, wcyc, wa, wdat, so);
    checks++;
    if (lat !== 1 || e !== 1'b1 || d !== 32'h0 || wc !== 0) begin
      errors++;
      $display("[TB] FAIL illegal: got lat=%0d err=%b rdata=%h wren=%0d, expected lat=1 err=1 rdata=0 wren=0", lat, e, d, wc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bData [3];
    int accCyc [3];
    int nAcc, nWren, guard;
    bit pend;
    for (int i = 0; i < 3; i++) bData[i] = $urandom;
    nAcc = 0; nWren = 0; guard = 0;
    sel = 1'b0;
    @(negedge clock);
    while (!mReady && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    ctrlSw = 1'b1; ctrlLw = 1'b0; addrIn = 32'h10; wdataIn = bData[0];
    reqValid1 = 1'b1;
    pend = mReady;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (pend) begin
        if (nAcc < 3) accCyc[nAcc] = k;
        nAcc++;
        if (nAcc < 3) begin
          addrIn = 32'h10 + 32'(nAcc);
          wdataIn = bData[nAcc];
        end else begin
          reqValid1 = 1'b0;
        end
      end
      if (mWren) begin
        if (nWren < 3) begin
          checks++;
          if (mDmemAddr !== 12'(12'h10 + nWren) || mDmemData !== bData[nWren]) begin
            errors++;
            $display("[TB] FAIL b2b_wren%0d: got addr=%h data=%h, expected addr=%h data=%h",
                     nWren, mDmemAddr, mDmemData, 12'(12'h10 + nWren), bData[nWren]);
          end
        end
        nWren++;
      end
      pend = reqValid1 && mReady;
    end
    reqValid1 = 1'b0;
    for (int i = 0; i < 3; i++) refWrite(1'b0, 12'(12'h10 + i), bData[i]);
    checks++;
    if (nAcc !== 3 || nWren !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_counts: got accepts=%0d wren=%0d, expected 3 and 3", nAcc, nWren);
    end else begin
      checks++;
      if (accCyc[1] - accCyc[0] !== 3 || accCyc[2] - accCyc[1] !== 3) begin
        errors++;
        $display("[TB] FAIL b2b_spacing: got %0d,%0d, expected 3,3", accCyc[1] - accCyc[0], accCyc[2] - accCyc[1]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int lat, wc, wcyc, pulses; logic e; logic [31:0] d, wdat, val; logic [11:0] wa; bit so;
    val = $urandom;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h020, val, lat, e, d, wc, wcyc, wa, wdat, so);
    refWrite(1'b1, 12'h020, val);
    checks++;
    if (lat !== 2 || wc !== 1 || wdat !== val) begin
      errors++;
      $display("[TB] FAIL lat3_store: got lat=%0d wren=%0d data=%h, expected lat=2 wren=1 data=%h", lat, wc, wdat, val);
    end
    @(negedge clock);
    ctrlSw = 1'b0; ctrlLw = 1'b1; addrIn = 32'h020;
    reqValid3 = 1'b1;
    @(negedge clock);
    reqValid3 = 1'b0;
    @(negedge clock);
    rstN3 = 1'b0;
    #1;
    checks++;
    if ({mReady, mRspValid, mErr, mStall, mWren, mDmemAddr, mDmemData, mRdata} !==
        {1'b1, 4'b0000, 12'h000, 32'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL midload_reset: got rdy=%b rv=%b err=%b stall=%b wren=%b addr=%h data=%h rdata=%h",
               mReady, mRspValid, mErr, mStall, mWren, mDmemAddr, mDmemData, mRdata);
    end
    pulses = 0;
    @(negedge clock);
    rstN3 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (mRspValid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL midload_no_rsp: got %0d rsp pulses, expected 0", pulses);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h020, 32'h0, lat, e, d, wc, wcyc, wa, wdat, so);
    checks++;
    if (lat !== 5 || e !== 1'b0 || d !== refRead(1'b1, 12'h020) || !so) begin
      errors++;
      $display("[TB] FAIL load_after_reset: got lat=%0d err=%b rdata=%h stall=%b, expected lat=5 err=0 rdata=%h stall=1",
               lat, e, d, so, refRead(1'b1, 12'h020));
    end
  endtask

  task automatic test_random();
    int lat, wc, wcyc, kind, expLat, expWren; logic e, sw, lw, expErr, rangeE; bit s, so;
    logic [31:0] d, wdat, a, wd; logic [11:0] wa;
    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 1) == 1;
      kind = $urandom_range(0, 3);
      sw = (kind == 0) || (kind == 3);
      lw = (kind == 1) || (kind == 3);
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_1000) : 32'($urandom_range(0, 31));
      wd = $urandom;
      rangeE = (a >= 32'h1000);
      expErr = rangeE || (kind == 3);
      expLat = (kind == 0) ? 2 : (kind == 1) ? (s ? 3 : 1) + 2 : 1;
      expWren = (kind == 0 && !rangeE) ? 1 : 0;
      applyStimulus(s, sw, lw, a, wd, lat, e, d, wc, wcyc, wa, wdat, so);
      checks++;
      if (lat !== expLat || e !== expErr || wc !== expWren || !so) begin
        errors++;
        $display("[TB] FAIL rand%0d_resp: kind=%0d addr=%h got lat=%0d err=%b wren=%0d stall=%b, expected lat=%0d err=%b wren=%0d",
                 n, kind, a, lat, e, wc, so, expLat, expErr, expWren);
      end
      if (expWren == 1) begin
        checks++;
        if (wa !== a[11:0] || wdat !== wd) begin
          errors++;
          $display("[TB] FAIL rand%0d_wdata: got addr=%h data=%h, expected addr=%h data=%h", n, wa, wdat, a[11:0], wd);
        end
        refWrite(s, a[11:0], wd);
      end
      if (kind == 1 || kind == 3) begin
        checks++;
        if (d !== ((kind == 3 || rangeE) ? 32'h0 : refRead(s, a[11:0]))) begin
          errors++;
          $display("[TB] FAIL rand%0d_rdata: got %h, expected %h", n, d,
                   (kind == 3 || rangeE) ? 32'h0 : refRead(s, a[11:0]));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      refMem1[i] = seedWord(12'(i));
      refMem3[i] = seedWord(12'(i));
    end
    sel = 1'b0;
    reqValid1 = 1'b0; reqValid3 = 1'b0; ctrlSw = 1'b0; ctrlLw = 1'b0;
    addrIn = '0; wdataIn = '0;
    rstN1 = 1'b1; rstN3 = 1'b1;
    #2;
    rstN1 = 1'b0; rstN3 = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    rstN1 = 1'b1; rstN3 = 1'b1;
    test_store();
    test_load_lat1();
    test_range();
    test_illegal();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
